// File: rtl/eth_frame_rx_param.sv
// rtl/eth_frame_rx_param.sv - serial Ethernet-style frame receiver with CRC-32 check
// Hunts preamble+SFD, captures DST/SRC/LEN, streams payload bytes, reports per-frame status.

module eth_frame_rx_param #(
   parameter int          PREAMBLE_BYTES = 7,
   parameter int          MAX_PAYLOAD    = 1500,
   parameter bit          ADDR_FILTER    = 1'b0,
   parameter logic [47:0] MY_MAC         = 48'h02_00_00_00_00_01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        signal,
   input  logic        bit_valid,
   output logic [47:0] mac_destination,
   output logic [47:0] mac_source,
   output logic [15:0] payload_len,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        frame_start,
   output logic        done,
   output logic        frame_ok,
   output logic        crc_err,
   output logic        len_err
);

   localparam int          HW       = 8 * (PREAMBLE_BYTES + 1);
   localparam int          CW       = $clog2(MAX_PAYLOAD + 1);
   localparam logic [HW-1:0] SYNC_PAT = {{PREAMBLE_BYTES{8'hAA}}, 8'hAB};
   localparam logic [31:0] POLY     = 32'h04C1_1DB7;
   localparam logic [31:0] MAX_L    = MAX_PAYLOAD;

   typedef enum logic [2:0] {ST_HUNT, ST_DST, ST_SRC, ST_LEN, ST_PAYLOAD, ST_FCS} state_t;

   state_t         state_q, state_d;
   logic [HW-2:0]  hunt_q, hunt_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
   logic [6:0]     byte_q, byte_d;
   logic [30:0]    fcs_q, fcs_d;
   logic [31:0]    crc_q, crc_d, crc_step;
   logic [47:0]    dst_q, dst_d, src_q, src_d;
   logic [15:0]    len_q, len_d;
   logic [7:0]     data_q, data_d;
   logic           data_valid_q, data_valid_d, frame_start_q, frame_start_d, done_q, done_d;
   logic           frame_ok_q, frame_ok_d, crc_err_q, crc_err_d, len_err_q, len_err_d;

   assign crc_step = {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ signal) ? POLY : 32'h0);

   always_comb begin
      state_d       = state_q;
      hunt_d        = hunt_q;
      cnt_d         = cnt_q;
      byte_cnt_d    = byte_cnt_q;
      byte_d        = byte_q;
      fcs_d         = fcs_q;
      crc_d         = crc_q;
      dst_d         = dst_q;
      src_d         = src_q;
      len_d         = len_q;
      data_d        = data_q;
      frame_ok_d    = frame_ok_q;
      crc_err_d     = crc_err_q;
      len_err_d     = len_err_q;
      data_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      done_d        = 1'b0;
      if (bit_valid) begin
         case (state_q)
            ST_HUNT: begin
               hunt_d = {hunt_q[HW-3:0], signal};
               // Cleared on match so stale sync bits cannot combine with the next frame's preamble
               if ({hunt_q, signal} == SYNC_PAT) begin
                  frame_start_d = 1'b1;
                  crc_d         = 32'hFFFF_FFFF;
                  hunt_d        = '0;
                  cnt_d         = '0;
                  state_d       = ST_DST;
               end
            end
            ST_DST: begin
               dst_d = {dst_q[46:0], signal};
               crc_d = crc_step;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd47) begin
                  cnt_d = '0;
                  if (ADDR_FILTER && (dst_d != MY_MAC) && (dst_d != 48'hFFFF_FFFF_FFFF))
                     state_d = ST_HUNT;
                  else
                     state_d = ST_SRC;
               end
            end
            ST_SRC: begin
               src_d = {src_q[46:0], signal};
               crc_d = crc_step;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd47) begin
                  cnt_d   = '0;
                  state_d = ST_LEN;
               end
            end
            ST_LEN: begin
               len_d = {len_q[14:0], signal};
               crc_d = crc_step;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd15) begin
                  cnt_d      = '0;
                  byte_cnt_d = '0;
                  if ({16'd0, len_d} > MAX_L) begin
                     done_d     = 1'b1;
                     frame_ok_d = 1'b0;
                     crc_err_d  = 1'b0;
                     len_err_d  = 1'b1;
                     state_d    = ST_HUNT;
                  end else if (len_d == 16'd0) begin
                     state_d = ST_FCS;
                  end else begin
                     state_d = ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               byte_d = {byte_q[5:0], signal};
               crc_d  = crc_step;
               cnt_d  = cnt_q + 6'd1;
               if (cnt_q == 6'd7) begin
                  cnt_d        = '0;
                  data_d       = {byte_q, signal};
                  data_valid_d = 1'b1;
                  byte_cnt_d   = byte_cnt_q + 1'b1;
                  if (byte_cnt_d == len_q[CW-1:0])
                     state_d = ST_FCS;
               end
            end
            ST_FCS: begin
               fcs_d = {fcs_q[29:0], signal};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  cnt_d      = '0;
                  done_d     = 1'b1;
                  frame_ok_d = ({fcs_q, signal} == ~crc_q);
                  crc_err_d  = ({fcs_q, signal} != ~crc_q);
                  len_err_d  = 1'b0;
                  state_d    = ST_HUNT;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_HUNT;
         hunt_q        <= '0;
         cnt_q         <= '0;
         byte_cnt_q    <= '0;
         byte_q        <= '0;
         fcs_q         <= '0;
         crc_q         <= '0;
         dst_q         <= '0;
         src_q         <= '0;
         len_q         <= '0;
         data_q        <= '0;
         data_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         done_q        <= 1'b0;
         frame_ok_q    <= 1'b0;
         crc_err_q     <= 1'b0;
         len_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         hunt_q        <= hunt_d;
         cnt_q         <= cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         byte_q        <= byte_d;
         fcs_q         <= fcs_d;
         crc_q         <= crc_d;
         dst_q         <= dst_d;
         src_q         <= src_d;
         len_q         <= len_d;
         data_q        <= data_d;
         data_valid_q  <= data_valid_d;
         frame_start_q <= frame_start_d;
         done_q        <= done_d;
         frame_ok_q    <= frame_ok_d;
         crc_err_q     <= crc_err_d;
         len_err_q     <= len_err_d;
      end
   end

   assign mac_destination = dst_q;
   assign mac_source      = src_q;
   assign payload_len     = len_q;
   assign data_out        = data_q;
   assign data_valid      = data_valid_q;
   assign frame_start     = frame_start_q;
   assign done            = done_q;
   assign frame_ok        = frame_ok_q;
   assign crc_err         = crc_err_q;
   assign len_err         = len_err_q;

endmodule

// File: tb/tb_eth_frame_rx_param.sv
// tb/tb_eth_frame_rx_param.sv - scoreboard bench for eth_frame_rx_param
// Stimulus pushes expected events; a negedge monitor pops and compares DUT pulses.

module tb_eth_frame_rx_param;

   localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] ME  = 48'h02_00_00_00_00_01;
   localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;
   localparam int EV_START = 0, EV_DATA = 1, EV_DONE = 2;

   logic        clk = 1'b0;
   logic        rst, signal, bit_valid;
   logic [47:0] mac_destination, mac_source;
   logic [15:0] payload_len;
   logic [7:0]  data_out;
   logic        data_valid, frame_start, done, frame_ok, crc_err, len_err;

   typedef struct {
      int          kind;
      logic [7:0]  b;
      logic [2:0]  flags;
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] len;
   } exp_t;

   exp_t       expq[$];
   int         vectors = 0;
   int         miscompares = 0;
   bit         gaps = 1'b0;
   logic [7:0] pl [4];

   eth_frame_rx_param #(
      .PREAMBLE_BYTES(7),
      .MAX_PAYLOAD(1500),
      .ADDR_FILTER(1'b1),
      .MY_MAC(ME)
   ) dut (
      .clk(clk),
      .rst(rst),
      .signal(signal),
      .bit_valid(bit_valid),
      .mac_destination(mac_destination),
      .mac_source(mac_source),
      .payload_len(payload_len),
      .data_out(data_out),
      .data_valid(data_valid),
      .frame_start(frame_start),
      .done(done),
      .frame_ok(frame_ok),
      .crc_err(crc_err),
      .len_err(len_err)
   );

   always #5 clk = ~clk;

   function automatic string kname(input int k);
      if (k == EV_START) return "frame_start";
      if (k == EV_DATA) return "data_valid";
      return "done";
   endfunction

   function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
      return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C1_1DB7 : 32'h0);
   endfunction

   task automatic take(input int kind, output exp_t e, output bit ok);
      vectors++;
      ok = 1'b0;
      if (expq.size() == 0) begin
         miscompares++;
         $display("FAIL %s: got unexpected pulse, required no event", kname(kind));
      end else begin
         e = expq.pop_front();
         if (e.kind != kind) begin
            miscompares++;
            $display("FAIL event_order: got %s, required %s", kname(kind), kname(e.kind));
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      if (frame_start) take(EV_START, e, ok);
      if (data_valid) begin
         take(EV_DATA, e, ok);
         if (ok) begin
            vectors++;
            if (data_out !== e.b) begin
               miscompares++;
               $display("FAIL data_out: got %h, required %h", data_out, e.b);
            end
         end
      end
      if (done) begin
         take(EV_DONE, e, ok);
         if (ok) begin
            vectors++;
            if ({frame_ok, crc_err, len_err} !== e.flags) begin
               miscompares++;
               $display("FAIL status ok/crc/len: got %b, required %b", {frame_ok, crc_err, len_err}, e.flags);
            end
            vectors++;
            if ({mac_destination, mac_source, payload_len} !== {e.dst, e.src, e.len}) begin
               miscompares++;
               $display("FAIL fields dst/src/len: got %h/%h/%h, required %h/%h/%h",
                        mac_destination, mac_source, payload_len, e.dst, e.src, e.len);
            end
         end
      end
   end

   task automatic exp_ev(input int kind, input logic [7:0] b, input logic [2:0] flags,
                         input logic [47:0] dst, input logic [15:0] len);
      exp_t e;
      e.kind  = kind;
      e.b     = b;
      e.flags = flags;
      e.dst   = dst;
      e.src   = SRC;
      e.len   = len;
      expq.push_back(e);
   endtask

   task automatic send_bit(input logic b);
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            bit_valid = 1'b0;
            @(negedge clk);
         end
      end
      signal    = b;
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic idle(input int n);
      bit_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // FCS always covers the unflipped payload so a flipped bit shows up as a CRC error
   task automatic send_frame(input int npre, input logic [47:0] dst, input logic [15:0] len,
                             input int nbytes, input int flip, input bit with_fcs);
      logic [31:0]  crc;
      logic [111:0] hdr;
      logic [7:0]   b;
      crc = 32'hFFFF_FFFF;
      hdr = {dst, SRC, len};
      repeat (npre) send_byte(8'hAA);
      send_byte(8'hAB);
      for (int i = 111; i >= 0; i--) begin
         send_bit(hdr[i]);
         crc = crc_bit(crc, hdr[i]);
      end
      for (int n = 0; n < nbytes; n++) begin
         b = pl[n];
         for (int i = 7; i >= 0; i--) begin
            send_bit(b[i] ^ ((n == flip) && (i == 0)));
            crc = crc_bit(crc, b[i]);
         end
      end
      if (with_fcs) begin
         crc = ~crc;
         for (int i = 31; i >= 0; i--) send_bit(crc[i]);
      end
   endtask

   task automatic expect_good(input logic [47:0] dst);
      exp_ev(EV_START, 8'h00, 3'b000, dst, 16'd4);
      for (int n = 0; n < 4; n++) exp_ev(EV_DATA, pl[n], 3'b000, dst, 16'd4);
      exp_ev(EV_DONE, 8'h00, 3'b100, dst, 16'd4);
   endtask

   task automatic check_zero(input string name);
      vectors++;
      if ({mac_destination, mac_source, payload_len, data_out, data_valid, frame_start,
           done, frame_ok, crc_err, len_err} !== '0) begin
         miscompares++;
         $display("FAIL %s: got dst=%h src=%h len=%h data=%h pulses=%b, required all zero", name,
                  mac_destination, mac_source, payload_len, data_out,
                  {data_valid, frame_start, done, frame_ok, crc_err, len_err});
      end
   endtask

   initial begin
      pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
      rst = 1'b1; signal = 1'b0; bit_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;
      idle(2);

      // good broadcast frame
      expect_good(BC);
      send_frame(7, BC, 16'd4, 4, -1, 1'b1);
      idle(4);

      // bit 0 of BE flipped -> BF strobed, CRC error
      exp_ev(EV_START, 8'h00, 3'b000, BC, 16'd4);
      exp_ev(EV_DATA, 8'hDE, 3'b000, BC, 16'd4);
      exp_ev(EV_DATA, 8'hAD, 3'b000, BC, 16'd4);
      exp_ev(EV_DATA, 8'hBF, 3'b000, BC, 16'd4);
      exp_ev(EV_DATA, 8'hEF, 3'b000, BC, 16'd4);
      exp_ev(EV_DONE, 8'h00, 3'b010, BC, 16'd4);
      send_frame(7, BC, 16'd4, 4, 2, 1'b1);
      idle(4);

      // length 1501 -> len_err right after the length field
      exp_ev(EV_START, 8'h00, 3'b000, BC, 16'h05DD);
      exp_ev(EV_DONE, 8'h00, 3'b001, BC, 16'h05DD);
      send_frame(7, BC, 16'h05DD, 0, -1, 1'b0);
      idle(4);
      expect_good(BC);
      send_frame(7, BC, 16'd4, 4, -1, 1'b1);
      idle(4);

      // filtered destination dropped silently, then own address accepted
      exp_ev(EV_START, 8'h00, 3'b000, 48'h02_00_00_00_00_99, 16'd4);
      send_frame(7, 48'h02_00_00_00_00_99, 16'd4, 4, -1, 1'b1);
      idle(4);
      expect_good(ME);
      send_frame(7, ME, 16'd4, 4, -1, 1'b1);
      idle(4);

      // long preamble, gaps, zero length; then a short preamble that must be ignored
      gaps = 1'b1;
      exp_ev(EV_START, 8'h00, 3'b000, BC, 16'd0);
      exp_ev(EV_DONE, 8'h00, 3'b100, BC, 16'd0);
      send_frame(12, BC, 16'd0, 0, -1, 1'b1);
      repeat (6) send_byte(8'hAA);
      send_byte(8'hAB);
      idle(20);
      gaps = 1'b0;

      // reset mid-payload
      exp_ev(EV_START, 8'h00, 3'b000, BC, 16'd4);
      exp_ev(EV_DATA, 8'hDE, 3'b000, BC, 16'd4);
      exp_ev(EV_DATA, 8'hAD, 3'b000, BC, 16'd4);
      send_frame(7, BC, 16'd4, 2, -1, 1'b0);
      repeat (3) send_bit(1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("mid_frame_reset");
      rst = 1'b0;
      idle(2);
      expect_good(BC);
      send_frame(7, BC, 16'd4, 4, -1, 1'b1);
      idle(6);

      vectors++;
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL pending_events: got %0d outstanding, required 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/eth_frame_rx_param.md
Name: eth_frame_rx_param

Overview:
- Parametrised serial Ethernet-style frame receiver. Replaces the fixed single-shot frame decoder.
- Consumes one bit per qualified clock. Hunts for preamble+SFD, then parses destination MAC, source MAC and the 16-bit length field.
- Streams payload bytes out as they complete, checks CRC-32 and reports a per-frame status. It then re-arms for the next frame; there is no single-shot behaviour.
- Sits between the line-bit recovery logic and the packet buffer.

Parameters:
- PREAMBLE_BYTES, 7, number of 0xAA bytes required before the SFD byte 0xAB.
- MAX_PAYLOAD, 1500, largest legal length-field value in bytes.
- ADDR_FILTER, 0, 1 = drop frames whose destination is neither MY_MAC nor broadcast.
- MY_MAC, 48'h02_00_00_00_00_01, station address used when ADDR_FILTER=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- signal  in  1  serial line bit, MSB of each byte first.
- bit_valid  in  1  signal is sampled only on cycles where this is 1; gaps of any length are legal.
- mac_destination  out  48  captured destination MAC; first received bit goes to bit 47.
- mac_source  out  48  captured source MAC, same bit order.
- payload_len  out  16  captured length field.
- data_out  out  8  payload byte.
- data_valid  out  1  one-cycle strobe per payload byte.
- frame_start  out  1  one-cycle pulse, cycle after SFD match.
- done  out  1  one-cycle pulse at end of frame or abort.
- frame_ok  out  1  status, valid with done, held until next done.
- crc_err  out  1  status, valid with done, held until next done.
- len_err  out  1  status, valid with done, held until next done.

Behaviour:
- Reset: all outputs 0; state HUNT; shift register, counters and CRC cleared. Reset mid-frame discards the frame and emits no done.
- All actions occur only on cycles with bit_valid=1, except pulse clearing. Every output is registered, so each response appears the cycle after the qualifying bit.
- HUNT: shift signal into an 8*(PREAMBLE_BYTES+1)-bit register. When it equals {PREAMBLE_BYTES x 8'hAA, 8'hAB}:
  - pulse frame_start;
  - load CRC with 32'hFFFF_FFFF;
  - go to DST.
  - Longer preambles are accepted (sliding match). A broken pattern simply keeps hunting.
- DST, 48 bits: shift into mac_destination and the CRC. After bit 48, if ADDR_FILTER=1 and the address is neither MY_MAC nor 48'hFFFF_FFFF_FFFF, return to HUNT silently (no done). Otherwise go to SRC.
- SRC, 48 bits: capture into mac_source, update CRC, go to LEN.
- LEN, 16 bits: capture into payload_len, update CRC. Then, with the length value L:
  - L > MAX_PAYLOAD: done=1, len_err=1, frame_ok=0, return to HUNT.
  - L == 0: go directly to FCS.
  - otherwise: go to PAYLOAD.
- PAYLOAD: assemble bytes MSB-first and update the CRC per bit. On the 8th bit of each byte, data_out and data_valid=1 are driven the next cycle.
  - The byte counter is $clog2(MAX_PAYLOAD+1) bits wide.
  - After byte L, go to FCS.
- FCS, 32 bits: shift the received bits into a register and do not feed them to the CRC. After bit 32:
  - compare with ~crc (transmitted FCS is the complemented CRC, MSB first);
  - done=1, frame_ok = match, crc_err = !match, len_err=0;
  - return to HUNT.
- CRC-32: polynomial 32'h04C11DB7, non-reflected, MSB-first serial LFSR. Feedback = crc[31] ^ signal; crc <= {crc[30:0],1'b0} ^ (feedback ? poly : 0).
- Captured fields stay stable until overwritten by the next frame's corresponding field.
- Preamble is not searched inside a frame. A frame truncated by loss of bit_valid simply stalls; there is no timeout in this block.

Test Plan:
1. Good frame. Stimulus: 7xAA, AB; dst FF:FF:FF:FF:FF:FF; src 02:00:00:00:00:01; len 0004; payload DE AD BE EF; FCS from the bench CRC model. Required: frame_start once; data_out DE,AD,BE,EF on four data_valid strobes; then done with frame_ok=1, crc_err=0; mac_source=48'h020000000001; payload_len=4.
2. Same frame with bit 0 of byte BE flipped -> done with crc_err=1, frame_ok=0; four bytes still strobed, including the corrupted BF.
3. len=16'h05DD (1501) -> done with len_err=1 right after the length field; no data_valid; next good frame decodes correctly.
4. ADDR_FILTER=1, dst 02:00:00:00:00:99 -> no done, no data_valid. Following frame to 02:00:00:00:00:01 -> frame_ok=1.
5. 12xAA preamble plus random bit_valid gaps, len=0 -> frame_start, then done with frame_ok=1 and no data_valid. Also: 6xAA then AB -> ignored.
6. rst asserted mid-payload -> all outputs 0 the next cycle, no done. A following good frame -> frame_ok=1.
